ex_result_stage: RTL and testbench

EX_RESULT_STAGE -- requirements
Module: ex_result_stage

---
 rtl/ex_result_stage_if.sv | 40 ++++
 rtl/ex_result_stage.sv | 117 +++++++++++
 tb/tb_ex_result_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ex_result_stage_if.sv
// Execute-to-memory stage bundle: upstream entry, flush, buffered downstream entry and branch redirect.
interface ex_result_stage_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic [1:0]      branch_type;
  logic [XLEN-1:0] branch_target;
  logic [4:0]      rd;
  logic            reg_write;
  logic            mem_read;
  logic            mem_write;
  logic [XLEN-1:0] store_data;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            out_zero;
  logic [4:0]      out_rd;
  logic            out_reg_write;
  logic            out_mem_read;
  logic            out_mem_write;
  logic [XLEN-1:0] out_store_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport slave (
    input  in_valid, alu_result, zero, branch_type, branch_target, rd, reg_write,
           mem_read, mem_write, store_data, flush, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_store_data, redirect_valid, redirect_pc
  );

  modport master (
    output in_valid, alu_result, zero, branch_type, branch_target, rd, reg_write,
           mem_read, mem_write, store_data, flush, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_rd, out_reg_write,
           out_mem_read, out_mem_write, out_store_data, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ex_result_stage.sv
// Execute result stage: 2-entry skid FIFO toward memory stage plus branch resolution redirect.
// Latency 1 cycle; in_ready is registered (count < 2) so out_ready never reaches it combinationally.
module ex_result_stage #(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  ex_result_stage_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
    logic            zero;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
  } meta_t;

  meta_t           mem [2];
  meta_t           in_entry;
  meta_t           head;
  logic [1:0]      count;
  logic [1:0]      count_nxt;
  logic            wr_ptr;
  logic            rd_ptr;
  logic            in_ready_q;
  logic            redirect_valid_q;
  logic [XLEN-1:0] redirect_pc_q;
  logic            accept;
  logic            dequeue;
  logic            taken;
  logic            not_empty;

  assign in_entry.result     = bus.alu_result;
  assign in_entry.store_data = bus.store_data;
  assign in_entry.zero       = bus.zero;
  assign in_entry.rd         = bus.rd;
  assign in_entry.reg_write  = bus.reg_write;
  assign in_entry.mem_read   = bus.mem_read;
  assign in_entry.mem_write  = bus.mem_write;

  assign not_empty = (count != 2'd0);
  assign accept    = bus.in_valid & in_ready_q & ~bus.flush;
  assign dequeue   = not_empty & bus.out_ready;

  always_comb begin
    taken = 1'b0;
    case (bus.branch_type)
      2'b01:   taken = bus.zero;
      2'b10:   taken = ~bus.zero;
      2'b11:   taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Flush wins over any accept/dequeue in the same cycle.
  always_comb begin
    count_nxt = count;
    if (bus.flush) begin
      count_nxt = 2'd0;
    end else if (accept && !dequeue) begin
      count_nxt = count + 2'd1;
    end else if (!accept && dequeue) begin
      count_nxt = count - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count            <= 2'd0;
      wr_ptr           <= 1'b0;
      rd_ptr           <= 1'b0;
      in_ready_q       <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      mem[0]           <= '0;
      mem[1]           <= '0;
    end else begin
      count            <= count_nxt;
      in_ready_q       <= (count_nxt != 2'd2);
      redirect_valid_q <= accept & taken;
      if (accept && taken) begin
        redirect_pc_q <= bus.branch_target;
      end
      if (bus.flush) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (accept) begin
          mem[wr_ptr] <= in_entry;
          wr_ptr      <= ~wr_ptr;
        end
        if (dequeue) begin
          rd_ptr <= ~rd_ptr;
        end
      end
    end
  end

  assign head = mem[rd_ptr];

  // Control bits are masked when empty so a stale slot never looks like a write.
  assign bus.in_ready       = in_ready_q;
  assign bus.out_valid      = not_empty;
  assign bus.out_result     = head.result;
  assign bus.out_store_data = head.store_data;
  assign bus.out_zero       = head.zero;
  assign bus.out_rd         = head.rd;
  assign bus.out_reg_write  = head.reg_write & not_empty;
  assign bus.out_mem_read   = head.mem_read & not_empty;
  assign bus.out_mem_write  = head.mem_write & not_empty;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_result_stage.sv
// Scoreboard bench for ex_result_stage: accepted entries queue expectations, a negedge monitor checks dequeues.
module tb_ex_result_stage;

  typedef struct packed {
    logic [63:0] res;
    logic [63:0] sd;
    logic        zero;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_pop = 0;
  exp_t exp_q[$];

  ex_result_stage_if #(.XLEN(64)) bus ();

  ex_result_stage #(.XLEN(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitor: pop before push so an entry appearing in its own accept cycle is caught.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (reset_n && bus.out_valid && bus.out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got result 0x%0h expected no entry", bus.out_result);
        end else begin
          e = exp_q.pop_front();
          got = '{res: bus.out_result, sd: bus.out_store_data, zero: bus.out_zero, rd: bus.out_rd,
                  rw: bus.out_reg_write, mr: bus.out_mem_read, mw: bus.out_mem_write};
          check("sb_result", got.res, e.res);
          check("sb_store_data", got.sd, e.sd);
          check("sb_ctrl", 64'({got.zero, got.rd, got.rw, got.mr, got.mw}),
                64'({e.zero, e.rd, e.rw, e.mr, e.mw}));
        end
      end
      if (reset_n && bus.flush) begin
        exp_q.delete();
      end else if (reset_n && bus.in_valid && bus.in_ready) begin
        exp_q.push_back('{res: bus.alu_result, sd: bus.store_data, zero: bus.zero, rd: bus.rd,
                          rw: bus.reg_write, mr: bus.mem_read, mw: bus.mem_write});
      end
    end
  end

  task automatic drive(input logic [63:0] res, input logic [63:0] sd, input logic z,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                       input logic [1:0] bt, input logic [63:0] tgt);
    bus.in_valid      = 1'b1;
    bus.alu_result    = res;
    bus.store_data    = sd;
    bus.zero          = z;
    bus.rd            = rd;
    bus.reg_write     = rw;
    bus.mem_read      = mr;
    bus.mem_write     = mw;
    bus.branch_type   = bt;
    bus.branch_target = tgt;
  endtask

  // Returns at posedge+1 right after the accepting edge; in_valid is dropped.
  task automatic wait_accept(input string name);
    logic rdy;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rdy = bus.in_ready & ~bus.flush;
      @(posedge clk);
      #1;
      if (rdy) begin
        bus.in_valid = 1'b0;
        return;
      end
    end
    check({name, "_accept_timeout"}, 64'd0, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_branch(input logic [1:0] bt, input logic z, input logic [63:0] tgt,
                             input logic exp_taken, input logic [63:0] res);
    drive(res, 64'h0, z, 5'd7, 1'b0, 1'b0, bt[0], bt, tgt);
    wait_accept("branch");
    @(negedge clk);
    check("redirect_valid", 64'(bus.redirect_valid), 64'(exp_taken));
    if (exp_taken) check("redirect_pc", bus.redirect_pc, tgt);
    @(negedge clk);
    check("redirect_pulse_end", 64'(bus.redirect_valid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(64'h0, 64'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0);
    bus.in_valid = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_redirect_valid", 64'(bus.redirect_valid), 64'd0);
    check("rst_redirect_pc", bus.redirect_pc, 64'd0);
    check("rst_out_result", bus.out_result, 64'd0);
    check("rst_out_reg_write", 64'(bus.out_reg_write), 64'd0);
    #10 reset_n = 1'b1;
    #1 check("in_ready_before_edge", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1 check("in_ready_after_reset", 64'(bus.in_ready), 64'd1);

    // Pass-through
    bus.out_ready = 1'b1;
    drive(64'h10, 64'hAA, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
    wait_accept("pass");
    @(negedge clk);
    check("pass_out_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk);
    check("pass_drained", 64'(bus.out_valid), 64'd0);
    check("empty_reg_write", 64'(bus.out_reg_write), 64'd0);
    @(posedge clk);
    #1;

    // Backpressure
    bus.out_ready = 1'b0;
    drive(64'h1, 64'h11, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
    wait_accept("bp1");
    drive(64'h2, 64'h22, 1'b1, 5'd2, 1'b0, 1'b1, 1'b0, 2'b00, 64'h0);
    wait_accept("bp2");
    drive(64'h3, 64'h33, 1'b0, 5'd4, 1'b0, 1'b0, 1'b1, 2'b00, 64'h0);
    @(negedge clk);
    check("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
    check("bp_head", bus.out_result, 64'h1);
    @(negedge clk);
    check("bp_head_stable", bus.out_result, 64'h1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    wait_accept("bp3");
    repeat (4) @(posedge clk);
    #1;

    // Branch decisions
    send_branch(2'b01, 1'b1, 64'h400, 1'b1, 64'hB0);
    send_branch(2'b10, 1'b1, 64'h500, 1'b0, 64'hB1);
    send_branch(2'b11, 1'b0, 64'h600, 1'b1, 64'hB2);
    send_branch(2'b10, 1'b0, 64'h700, 1'b1, 64'hB3);
    send_branch(2'b00, 1'b1, 64'h780, 1'b0, 64'hB4);

    // Flush with count 1: taken B in the flush cycle is neither accepted nor redirected
    bus.out_ready = 1'b0;
    drive(64'h77, 64'h0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
    wait_accept("fl1");
    drive(64'h78, 64'h0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 2'b11, 64'h900);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush1_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush1_redirect", 64'(bus.redirect_valid), 64'd0);
    @(posedge clk);
    #1;

    // Flush collision at count 2
    drive(64'h81, 64'h0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
    wait_accept("fl2a");
    drive(64'h82, 64'h0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
    wait_accept("fl2b");
    drive(64'h83, 64'h0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 2'b11, 64'h800);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush2_out_valid", 64'(bus.out_valid), 64'd0);
    check("flush2_redirect", 64'(bus.redirect_valid), 64'd0);
    check("flush2_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Async reset mid-operation with a pending redirect
    drive(64'h21, 64'h0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
    wait_accept("rs1");
    drive(64'h22, 64'h0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 2'b11, 64'hA00);
    wait_accept("rs2");
    #1 check("rs_redirect_pending", 64'(bus.redirect_valid), 64'd1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(bus.out_valid), 64'd0);
    check("arst_redirect", 64'(bus.redirect_valid), 64'd0);
    check("arst_redirect_pc", bus.redirect_pc, 64'd0);
    check("arst_in_ready", 64'(bus.in_ready), 64'd0);
    check("arst_out_result", bus.out_result, 64'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1 check("rs_in_ready", 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b1;
    drive(64'h55, 64'h5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0);
    wait_accept("rs3");
    @(negedge clk);
    check("rs_latency1_valid", 64'(bus.out_valid), 64'd1);
    check("rs_latency1_result", bus.out_result, 64'h55);
    check("rs_no_stale_redirect", 64'(bus.redirect_valid), 64'd0);
    @(negedge clk);
    check("rs_drained", 64'(bus.out_valid), 64'd0);

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    check("delivered_count", 64'(n_pop), 64'd10);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
